// File: rtl/cnn1d_pkg.sv
// Shared 1D-CNN types and the activation function used by relu_arbiter.
// Optional macro RELU_ARB_LEAKY_EN selects leaky ReLU instead of standard ReLU.
package cnn1d_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int LEAK_SHIFT = 3;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    function automatic data_t relu_f(input data_t x);
        data_t y;
`ifdef RELU_ARB_LEAKY_EN
        y = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
`else
        y = x[DATA_WIDTH-1] ? '0 : x;
`endif
        return y;
    endfunction

endpackage

// File: rtl/relu_arbiter_if.sv
// Lane request bus and activated result bus of relu_arbiter.
// The master side is the lane/consumer environment; the slave side is the arbiter.
interface relu_arbiter_if
    import cnn1d_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = $clog2(N_REQ)
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [ID_WIDTH-1:0]         out_id;
    logic                        out_ready;
    logic                        busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; the pointer only advances when the
// granted request is actually transferred.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;
    logic          w_found;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        w_cand       = '0;
        w_found      = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = wrap_idx(r_ptr, k);
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                grant_idx = w_cand;
            end
        end
        grant_onehot[grant_idx] = w_found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/relu_arbiter.sv
// Shares one ReLU stage between N_REQ lanes: round-robin grant, activation and a
// one-deep registered output tagged with the source lane (leaky via RELU_ARB_LEAKY_EN).
module relu_arbiter
    import cnn1d_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = $clog2(N_REQ)
) (
    input logic                clk,
    input logic                rst,
    relu_arbiter_if.slave      bus
);

    logic [N_REQ-1:0]    w_grant_oh;
    logic [ID_WIDTH-1:0] w_grant_idx;
    logic                w_accept;
    logic                w_xfer;
    data_t               w_sel;

    logic                r_vld_p1;
    data_t               r_data_p1;
    logic [ID_WIDTH-1:0] r_id_p1;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_WIDTH)
    ) u_rr (
        .clk          (clk),
        .rst          (rst),
        .req          (bus.req_valid),
        .advance      (w_xfer),
        .grant_onehot (w_grant_oh),
        .grant_idx    (w_grant_idx)
    );

    assign w_accept = !r_vld_p1 || bus.out_ready;
    // Reset gating keeps req_ready low while rst is held, not just after the edge.
    assign bus.req_ready = rst ? '0 : (w_grant_oh & {N_REQ{w_accept}});
    assign w_xfer        = |(bus.req_valid & bus.req_ready);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == ID_WIDTH'(i)) w_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // stage p1: activated result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_id_p1   <= '0;
        end else if (w_accept) begin
            r_vld_p1 <= w_xfer;
            if (w_xfer) begin
                r_data_p1 <= relu_f(w_sel);
                r_id_p1   <= w_grant_idx;
            end
        end
    end

    assign bus.out_valid = r_vld_p1;
    assign bus.out_data  = r_data_p1;
    assign bus.out_id    = r_id_p1;
    assign bus.busy      = r_vld_p1 || (|bus.req_valid);

endmodule
